card_regfile_ctrl: RTL

CARD_REGFILE_CTRL -- requirements
Module: card_regfile_ctrl

---
 rtl/card_regfile_ctrl_if.sv | 21 ++
 rtl/card_regfile_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/card_regfile_ctrl_if.sv
// Game-logic write handshake plus register-file write port.
// master: game logic / register file side; slave: card_regfile_ctrl.
interface card_regfile_ctrl_if;
    logic        gl_req;
    logic [3:0]  gl_addr;
    logic [13:0] gl_data;
    logic        gl_ack;
    logic        rf_we;
    logic [3:0]  rf_addr;
    logic [13:0] rf_wdata;

    modport master (
        output gl_req, gl_addr, gl_data,
        input  gl_ack, rf_we, rf_addr, rf_wdata
    );

    modport slave (
        input  gl_req, gl_addr, gl_data,
        output gl_ack, rf_we, rf_addr, rf_wdata
    );
endinterface

// File: rtl/card_regfile_ctrl.sv
// Card register-file controller: clears reg 0, loads regs 1..12 from the
// color computer, then grants game-logic writes one per cycle.
// Ports: clk, rst (sync, active-low), start, cc_enable/cc_done/cc_addr/
// cc_data (color computer), bus (gl_* handshake + rf_* write port), busy, ready.
// Optional macro SHUFFLE_EN: rotates init addresses by a seed latched at start.
module card_regfile_ctrl (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               cc_enable,
    input  logic               cc_done,
    input  logic [3:0]         cc_addr,
    input  logic [13:0]        cc_data,
    card_regfile_ctrl_if.slave bus,
    output logic               busy,
    output logic               ready
);
    typedef enum logic [2:0] {
        IDLE, CLEAR0, INIT, FLUSH, READY
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic [3:0]  addr_q, addr_d;
    logic [13:0] data_q, data_d;
    logic [3:0]  map_addr;
    logic        cc_valid;

    assign cc_valid = (cc_addr != 4'h0) && (cc_addr <= 4'hC);

`ifdef SHUFFLE_EN
    logic [3:0] cnt_q, seed_q;
    logic [4:0] sum, wrap;
    logic       start_ok;

    assign start_ok = start && ((state_q == IDLE) || (state_q == READY));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 4'd0;
            seed_q <= 4'd0;
        end else begin
            cnt_q <= (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
            if (start_ok) seed_q <= cnt_q;
        end
    end

    // Rotate 1..12 by seed, staying inside 1..12.
    assign sum      = {1'b0, cc_addr} - 5'd1 + {1'b0, seed_q};
    assign wrap     = (sum >= 5'd12) ? sum - 5'd12 : sum;
    assign map_addr = 4'(wrap + 5'd1);
`else
    assign map_addr = cc_addr;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        addr_d  = 4'h0;
        data_d  = 14'h0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR0;
            end
            CLEAR0: begin
                we_d    = 1'b1;
                state_d = INIT;
            end
            INIT: begin
                if (cc_valid) begin
                    we_d   = 1'b1;
                    addr_d = map_addr;
                    data_d = cc_data;
                end
                if (cc_done) state_d = FLUSH;
            end
            FLUSH: begin
                // Captures the final cc_addr=C pair.
                if (cc_valid) begin
                    we_d   = 1'b1;
                    addr_d = map_addr;
                    data_d = cc_data;
                end
                state_d = READY;
            end
            READY: begin
                // Restart wins over a coincident request.
                if (start) begin
                    state_d = CLEAR0;
                end else if (bus.gl_req) begin
                    we_d   = 1'b1;
                    ack_d  = 1'b1;
                    addr_d = bus.gl_addr;
                    data_d = bus.gl_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            addr_q  <= 4'h0;
            data_q  <= 14'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign cc_enable    = (state_q == INIT) || (state_q == FLUSH);
    assign busy         = (state_q == CLEAR0) || cc_enable;
    assign ready        = (state_q == READY);
    assign bus.rf_we    = we_q;
    assign bus.gl_ack   = ack_q;
    assign bus.rf_addr  = addr_q;
    assign bus.rf_wdata = data_q;
endmodule
